stack_controller: RTL and testbench

Pointer and top-of-stack manager that sits directly upstream of the `stack` register-file RAM and drives all of its ports. Used for both the data stack and the return stack of the j2 core. It keeps the top-of-stack (TOS) in a local register and spills the remaining entries into the RAM. It also tracks depth and flags overflow and underflow. The execute stage issues one stack command per cycle and reads TOS and NOS back combinationally.

---
 rtl/stack_controller.sv | 86 ++++++++
 tb/tb_stack_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// stack_controller: TOS register plus spill-pointer manager driving the stack RAM
module stack_controller #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             active_low_reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             error,
    output logic [DEPTH-1:0] ram_read_address,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic             ram_write_enable,
    output logic [DEPTH-1:0] ram_write_address,
    output logic [WIDTH-1:0] ram_write_data
);
    typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} op_t;

    // Capacity is the RAM slots plus the TOS register: 2**DEPTH + 1
    localparam logic [DEPTH:0] CAP = {1'b1, {(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH:0] TWO = {{(DEPTH-1){1'b0}}, 2'b10};

    op_t              cmd;
    logic [DEPTH-1:0] sp;

    assign cmd = op_t'(op);

    // Decoded status and RAM-side wiring; a PUSH spills old TOS into the slot above sp
    always_comb begin
        empty             = (count == '0);
        full              = (count == CAP);
        next              = (count >= TWO) ? ram_read_data : '0;
        ram_read_address  = sp;
        ram_write_address = sp + 1'b1;
        ram_write_data    = top;
        ram_write_enable  = active_low_reset && cmd == OP_PUSH && !empty && !full;
    end

    // Stack state update; overflow and underflow only set the sticky error flag
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            top   <= '0;
            sp    <= '1;
            count <= '0;
            error <= 1'b0;
        end else begin
            case (cmd)
                OP_NOP: ;
                OP_PUSH: begin
                    if (empty) begin
                        top   <= data_in;
                        count <= ONE;
                    end else if (full) begin
                        error <= 1'b1;
                    end else begin
                        sp    <= sp + 1'b1;
                        top   <= data_in;
                        count <= count + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        error <= 1'b1;
                    end else if (count == ONE) begin
                        top   <= '0;
                        count <= '0;
                    end else begin
                        top   <= ram_read_data;
                        sp    <= sp - 1'b1;
                        count <= count - 1'b1;
                    end
                end
                OP_REPLACE: begin
                    top <= data_in;
                    if (empty) count <= ONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: scoreboard bench for stack_controller with an attached RAM model
module tb_stack_controller;
    localparam int CAP = 17;
    localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

    typedef struct {
        int          id;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] top;
        logic [15:0] nxt;
        logic [4:0]  cnt;
        logic        emp;
        logic        ful;
        logic        err;
        logic [3:0]  raddr;
    } exp_t;

    logic        clock = 1'b0;
    logic        active_low_reset = 1'b0;
    logic [1:0]  op = NOP;
    logic [15:0] data_in = '0;
    logic [15:0] top, next, ram_read_data, ram_write_data;
    logic [4:0]  count;
    logic        empty, full, error, ram_write_enable;
    logic [3:0]  ram_read_address, ram_write_address;
    logic [15:0] mem [16];

    exp_t        sb[$];
    exp_t        mr;
    logic [15:0] mq[$];
    logic        merr = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          issued = 0;

    stack_controller #(.DEPTH(4), .WIDTH(16)) dut (
        .clock(clock),
        .active_low_reset(active_low_reset),
        .op(op),
        .data_in(data_in),
        .top(top),
        .next(next),
        .count(count),
        .empty(empty),
        .full(full),
        .error(error),
        .ram_read_address(ram_read_address),
        .ram_read_data(ram_read_data),
        .ram_write_enable(ram_write_enable),
        .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
    assign ram_read_data = mem[ram_read_address];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Issue one command at a falling edge and queue the response expected from a plain software stack
    task automatic cmd(input logic [1:0] o, input logic [15:0] d);
        exp_t r;
        int   n;
        @(negedge clock);
        op = o;
        data_in = d;
        n = mq.size();
        r.id    = issued++;
        r.we    = active_low_reset && o == PUSH && n >= 1 && n < CAP;
        r.waddr = 4'(n - 1);
        r.wdata = (n > 0) ? mq[n-1] : 16'h0;
        if (!active_low_reset) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            case (o)
                PUSH: if (n == CAP) merr = 1'b1; else mq.push_back(d);
                POP:  if (n == 0) merr = 1'b1; else void'(mq.pop_back());
                REPL: if (n == 0) mq.push_back(d); else mq[n-1] = d;
                default: ;
            endcase
        end
        n = mq.size();
        r.top   = (n > 0) ? mq[n-1] : 16'h0;
        r.nxt   = (n > 1) ? mq[n-2] : 16'h0;
        r.cnt   = 5'(n);
        r.emp   = (n == 0);
        r.ful   = (n == CAP);
        r.err   = merr;
        r.raddr = (n == 0) ? 4'hf : 4'(n - 2);
        sb.push_back(r);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clock);
            op = NOP;
        end
    endtask

    // Monitor: strobe checks before the edge, state checks just after it
    initial forever begin
        @(negedge clock);
        #2;
        if (sb.size() != 0) begin
            mr = sb.pop_front();
            check($sformatf("we#%0d", mr.id), ram_write_enable, mr.we);
            if (mr.we) begin
                check($sformatf("waddr#%0d", mr.id), ram_write_address, mr.waddr);
                check($sformatf("wdata#%0d", mr.id), ram_write_data, mr.wdata);
            end
            @(posedge clock);
            #1;
            check($sformatf("top#%0d", mr.id), top, mr.top);
            check($sformatf("next#%0d", mr.id), next, mr.nxt);
            check($sformatf("count#%0d", mr.id), count, mr.cnt);
            check($sformatf("empty#%0d", mr.id), empty, mr.emp);
            check($sformatf("full#%0d", mr.id), full, mr.ful);
            check($sformatf("error#%0d", mr.id), error, mr.err);
            check($sformatf("sp#%0d", mr.id), ram_read_address, mr.raddr);
        end
    end

    initial begin
        cmd(PUSH, 16'h1234);
        idle(1);
        active_low_reset = 1'b1;
        cmd(PUSH, 16'h0011);
        cmd(PUSH, 16'h0022);
        cmd(PUSH, 16'h0033);
        repeat (3) cmd(POP, 16'h0);
        cmd(POP, 16'h0);
        cmd(PUSH, 16'h00aa);
        cmd(POP, 16'h0);
        cmd(PUSH, 16'h0005);
        cmd(PUSH, 16'h0006);
        cmd(REPL, 16'h0007);
        cmd(NOP, 16'hdead);
        cmd(POP, 16'h0);
        cmd(POP, 16'h0);
        for (int i = 1; i <= 10; i++) cmd(PUSH, 16'(i));
        idle(2);
        op = PUSH;
        data_in = 16'h0077;
        #1 active_low_reset = 1'b0;
        #1;
        check("async_rst_count", count, 5'd0);
        check("async_rst_top", top, 16'h0);
        check("async_rst_sp", ram_read_address, 4'hf);
        check("async_rst_we", ram_write_enable, 1'b0);
        mq.delete();
        merr = 1'b0;
        op = NOP;
        #1 active_low_reset = 1'b1;
        cmd(PUSH, 16'h0001);
        cmd(PUSH, 16'h0002);
        idle(2);
        check("ram_slot0", mem[0], 16'h0001);
        cmd(POP, 16'h0);
        cmd(POP, 16'h0);
        for (int i = 1; i <= 17; i++) cmd(PUSH, 16'(i));
        cmd(PUSH, 16'd18);
        for (int i = 0; i < 17; i++) cmd(POP, 16'h0);
        idle(3);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
